// File: rtl/modexp_arbiter_if.sv
// Purpose : bundles the requester-side and engine-side buses of modexp_arbiter.
// Latency : none, wires only.
// Backpressure: carried by the req/ack and ready/valid handshakes inside; none added here.
//
// Modports:
//   slave  - arbiter view: requests, operands and engine responses in; acks, dones,
//            result, engine start and latched operands out.
//   master - requesters and engine view, the mirror of slave.
interface modexp_arbiter_if #(
   parameter int NUM_REQ   = 2,
   parameter int MSG_BYTES = 2,
   parameter int KEY_BYTES = 4
);
   localparam int MSG_W = 8 * MSG_BYTES;
   localparam int KEY_W = 8 * KEY_BYTES;
   localparam int ID_W  = $clog2(NUM_REQ);

   // requester side
   logic [NUM_REQ-1:0]       req_in;
   logic [NUM_REQ*MSG_W-1:0] value_in;
   logic [NUM_REQ*KEY_W-1:0] modulus_in;
   logic [NUM_REQ*KEY_W-1:0] exponent_in;
   logic [NUM_REQ-1:0]       ack_out;
   logic [NUM_REQ-1:0]       done_out;
   logic [KEY_W-1:0]         value_out;
   logic [ID_W-1:0]          id_out;
   logic                     busy_out;

   // engine side
   logic                     eng_rst_out;
   logic                     eng_ready_out;
   logic [MSG_W-1:0]         eng_value_out;
   logic [KEY_W-1:0]         eng_modulus_out;
   logic [KEY_W-1:0]         eng_exponent_out;
   logic                     eng_busy_in;
   logic                     eng_valid_in;
   logic [KEY_W-1:0]         eng_value_in;

   modport slave (
      input  req_in, value_in, modulus_in, exponent_in,
      input  eng_busy_in, eng_valid_in, eng_value_in,
      output ack_out, done_out, value_out, id_out, busy_out,
      output eng_rst_out, eng_ready_out, eng_value_out, eng_modulus_out, eng_exponent_out
   );

   modport master (
      output req_in, value_in, modulus_in, exponent_in,
      output eng_busy_in, eng_valid_in, eng_value_in,
      input  ack_out, done_out, value_out, id_out, busy_out,
      input  eng_rst_out, eng_ready_out, eng_value_out, eng_modulus_out, eng_exponent_out
   );
endinterface

// File: rtl/modexp_arbiter.sv
// Purpose : shares one exponent_modulus engine between NUM_REQ requesters, latching the winner's operands.
// Latency : ack 1 cycle after req is sampled, engine start at the earliest 1 cycle later, done 2 cycles after engine valid.
// Backpressure: requests are held until ack and ignored while busy; the engine is started only when its busy and valid are low.
//
// Ports:
//   clk_in   - clock
//   rst_n_in - asynchronous active-low reset; also forwarded (inverted) to the engine
//   bus      - modexp_arbiter_if.slave: req/ack/done and operand slots towards the
//              requesters, ready/valid plus latched operands towards the engine
//
// Build option: define MODEXP_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no pointer); otherwise round robin starting at the slot after the last served.
module modexp_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int MSG_BYTES = 2,
   parameter int KEY_BYTES = 4
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   modexp_arbiter_if.slave bus
);
   localparam int MSG_W = 8 * MSG_BYTES;
   localparam int KEY_W = 8 * KEY_BYTES;
   localparam int ID_W  = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [NUM_REQ-1:0] r_ack;
   logic [NUM_REQ-1:0] w_ack_nxt;
   logic [NUM_REQ-1:0] r_done;
   logic [NUM_REQ-1:0] w_done_nxt;
   logic               r_busy;
   logic               w_busy_nxt;
   logic [ID_W-1:0]    r_id;
   logic [ID_W-1:0]    w_id_nxt;
   logic [KEY_W-1:0]   r_value;
   logic [KEY_W-1:0]   w_value_nxt;

   logic               r_eng_ready;
   logic               w_eng_ready_nxt;
   logic [MSG_W-1:0]   r_eng_value;
   logic [MSG_W-1:0]   w_eng_value_nxt;
   logic [KEY_W-1:0]   r_eng_modulus;
   logic [KEY_W-1:0]   w_eng_modulus_nxt;
   logic [KEY_W-1:0]   r_eng_exponent;
   logic [KEY_W-1:0]   w_eng_exponent_nxt;

   logic               w_gnt_vld;
   logic [ID_W-1:0]    w_gnt_idx;

   logic [MSG_W-1:0]   w_slot_value;
   logic [KEY_W-1:0]   w_slot_modulus;
   logic [KEY_W-1:0]   w_slot_exponent;

   // ------------------------------------------------------------------
   // Grant selection
   // ------------------------------------------------------------------
`ifdef MODEXP_ARB_FIXED_PRIO_EN
   // Scan from the top down so the lowest set index is the last to land.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req_in[k]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = ID_W'(k);
         end
      end
   end
`else
   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_cand;

   // First set request at or above the pointer, wrapping; a requester that
   // was just served sits at the far end of the search.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
         if (!w_gnt_vld && bus.req_in[w_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_ptr <= '0;
      end else if (r_state == ST_DONE) begin
         r_ptr <= ID_W'((int'(r_id) + 1) % NUM_REQ);
      end
   end
`endif

   // Operand mux for the winning slot.
   always_comb begin
      w_slot_value    = '0;
      w_slot_modulus  = '0;
      w_slot_exponent = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt_idx == ID_W'(i)) begin
            w_slot_value    = bus.value_in[i*MSG_W +: MSG_W];
            w_slot_modulus  = bus.modulus_in[i*KEY_W +: KEY_W];
            w_slot_exponent = bus.exponent_in[i*KEY_W +: KEY_W];
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and next register values
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt        = r_state;
      w_ack_nxt          = '0;
      w_done_nxt         = '0;
      w_busy_nxt         = r_busy;
      w_id_nxt           = r_id;
      w_value_nxt        = r_value;
      w_eng_ready_nxt    = 1'b0;
      w_eng_value_nxt    = r_eng_value;
      w_eng_modulus_nxt  = r_eng_modulus;
      w_eng_exponent_nxt = r_eng_exponent;

      case (r_state)
         ST_IDLE: begin
            if (r_busy) begin
               // The done pulse is visible this cycle; busy covers it and
               // then drops, so no new request is taken in the done cycle.
               w_busy_nxt = 1'b0;
            end else if (w_gnt_vld) begin
               w_id_nxt           = w_gnt_idx;
               w_eng_value_nxt    = w_slot_value;
               w_eng_modulus_nxt  = w_slot_modulus;
               w_eng_exponent_nxt = w_slot_exponent;
               w_ack_nxt          = NUM_REQ'(1) << w_gnt_idx;
               w_busy_nxt         = 1'b1;
               w_state_nxt        = ST_LAUNCH;
            end
         end

         ST_LAUNCH: begin
            // A valid still high from an earlier job would be mistaken for
            // this job's result, so wait for the engine to be fully quiet.
            if (!bus.eng_busy_in && !bus.eng_valid_in) begin
               w_eng_ready_nxt = 1'b1;
               w_state_nxt     = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (bus.eng_valid_in) begin
               w_value_nxt = bus.eng_value_in;
               w_state_nxt = ST_DONE;
            end
         end

         ST_DONE: begin
            w_done_nxt  = NUM_REQ'(1) << r_id;
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output and operand registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_ack          <= '0;
         r_done         <= '0;
         r_busy         <= 1'b0;
         r_id           <= '0;
         r_value        <= '0;
         r_eng_ready    <= 1'b0;
         r_eng_value    <= '0;
         r_eng_modulus  <= '0;
         r_eng_exponent <= '0;
      end else begin
         r_ack          <= w_ack_nxt;
         r_done         <= w_done_nxt;
         r_busy         <= w_busy_nxt;
         r_id           <= w_id_nxt;
         r_value        <= w_value_nxt;
         r_eng_ready    <= w_eng_ready_nxt;
         r_eng_value    <= w_eng_value_nxt;
         r_eng_modulus  <= w_eng_modulus_nxt;
         r_eng_exponent <= w_eng_exponent_nxt;
      end
   end

   // The engine has a synchronous active-high reset; driving it straight from
   // our reset keeps it held for as long as we are.
   assign bus.eng_rst_out      = ~rst_n_in;

   assign bus.ack_out          = r_ack;
   assign bus.done_out         = r_done;
   assign bus.busy_out         = r_busy;
   assign bus.id_out           = r_id;
   assign bus.value_out        = r_value;
   assign bus.eng_ready_out    = r_eng_ready;
   assign bus.eng_value_out    = r_eng_value;
   assign bus.eng_modulus_out  = r_eng_modulus;
   assign bus.eng_exponent_out = r_eng_exponent;

endmodule

// File: tb/tb_modexp_arbiter.sv
// Directed bench for modexp_arbiter with a behavioural modexp engine of fixed latency.
// The engine computes from the arbiter's latched operands when it returns, so any
// operand that moves during a job shows up as a wrong result.
module tb_modexp_arbiter;
   localparam int NR    = 2;
   localparam int MB    = 2;
   localparam int KB    = 4;
   localparam int MSG_W = 8 * MB;
   localparam int KEY_W = 8 * KB;
   localparam int LAT   = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   modexp_arbiter_if #(.NUM_REQ(NR), .MSG_BYTES(MB), .KEY_BYTES(KB)) bus ();

   modexp_arbiter #(.NUM_REQ(NR), .MSG_BYTES(MB), .KEY_BYTES(KB)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   int n_tests   = 0;
   int n_fail    = 0;
   int ack_cnt   = 0;
   int ready_cnt = 0;
   int done_cnt  = 0;

   // ---------------- engine model ----------------
   logic             eng_busy_m  = 1'b0;
   logic             eng_valid_m = 1'b0;
   logic             force_valid = 1'b0;
   logic [KEY_W-1:0] eng_value_m = '0;
   int               eng_cnt     = 0;

   assign bus.eng_busy_in  = eng_busy_m;
   assign bus.eng_valid_in = eng_valid_m | force_valid;
   assign bus.eng_value_in = eng_value_m;

   function automatic logic [KEY_W-1:0] mexp(input logic [MSG_W-1:0] b,
                                             input logic [KEY_W-1:0] e,
                                             input logic [KEY_W-1:0] m);
      logic [63:0] r;
      logic [63:0] bb;
      logic [63:0] mm;
      mm = 64'(m);
      if (mm == 64'd0) return '0;
      r  = 64'd1 % mm;
      bb = 64'(b) % mm;
      for (int i = 0; i < KEY_W; i++) begin
         if (e[i]) r = (r * bb) % mm;
         bb = (bb * bb) % mm;
      end
      return r[KEY_W-1:0];
   endfunction

   always @(negedge clk) begin
      if (bus.eng_rst_out) begin
         eng_busy_m  = 1'b0;
         eng_valid_m = 1'b0;
         eng_cnt     = 0;
         eng_value_m = '0;
      end else begin
         eng_valid_m = 1'b0;
         if (bus.eng_ready_out && !eng_busy_m) begin
            eng_busy_m = 1'b1;
            eng_cnt    = LAT;
         end else if (eng_busy_m) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) begin
               eng_busy_m  = 1'b0;
               eng_valid_m = 1'b1;
               eng_value_m = mexp(bus.eng_value_out, bus.eng_exponent_out, bus.eng_modulus_out);
            end
         end
      end
   end

   // ---------------- event counters ----------------
   always @(negedge clk) begin
      if (bus.ack_out != '0) ack_cnt++;
      if (bus.eng_ready_out) ready_cnt++;
      if (bus.done_out != '0) done_cnt++;
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_slot(input int i, input logic [MSG_W-1:0] v,
                           input logic [KEY_W-1:0] e, input logic [KEY_W-1:0] m);
      bus.value_in[i*MSG_W +: MSG_W]    = v;
      bus.exponent_in[i*KEY_W +: KEY_W] = e;
      bus.modulus_in[i*KEY_W +: KEY_W]  = m;
   endtask

   // Wait for the next ack and its done; checks grant, id and result.
   task automatic serve(input string tag, input int slot, input logic [KEY_W-1:0] expv,
                        input bit keep_req);
      int t;
      t = 0;
      while (bus.ack_out == '0 && t < 40) begin tick(); t++; end
      chk($sformatf("%s ack", tag), 64'(bus.ack_out), 64'd1 << slot);
      chk($sformatf("%s id@ack", tag), 64'(bus.id_out), 64'(slot));
      if (!keep_req) bus.req_in = bus.req_in & ~bus.ack_out;
      t = 0;
      while (bus.done_out == '0 && t < 60) begin tick(); t++; end
      chk($sformatf("%s done", tag), 64'(bus.done_out), 64'd1 << slot);
      chk($sformatf("%s value", tag), 64'(bus.value_out), 64'(expv));
      chk($sformatf("%s id@done", tag), 64'(bus.id_out), 64'(slot));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      int t;
      int rc;
      int ac;
      int dc;
      int es;

      bus.req_in      = '0;
      bus.value_in    = '0;
      bus.modulus_in  = '0;
      bus.exponent_in = '0;
      repeat (3) tick();

      // reset state
      chk("rst ack", 64'(bus.ack_out), 64'd0);
      chk("rst done", 64'(bus.done_out), 64'd0);
      chk("rst busy", 64'(bus.busy_out), 64'd0);
      chk("rst value", 64'(bus.value_out), 64'd0);
      chk("rst id", 64'(bus.id_out), 64'd0);
      chk("rst eng_ready", 64'(bus.eng_ready_out), 64'd0);
      chk("rst eng operands", {bus.eng_value_out, bus.eng_exponent_out, bus.eng_modulus_out} == '0 ? 64'd0 : 64'd1, 64'd0);
      chk("rst eng_rst", 64'(bus.eng_rst_out), 64'd1);
      rst_n = 1'b1;
      tick();
      chk("eng_rst released", 64'(bus.eng_rst_out), 64'd0);

      // simultaneous requests, pointer at 0: slot 0 then slot 1
      set_slot(0, 16'd5, 32'd3, 32'd13);
      set_slot(1, 16'd7, 32'd0, 32'd11);
      bus.req_in = 2'b11;
      serve("sim first", 0, 32'd8, 1'b0);
      serve("sim second", 1, 32'd1, 1'b0);
      repeat (2) tick();

      // single request with cycle-level timing
      rc = ready_cnt;
      bus.req_in = 2'b01;
      tick();
      chk("single ack", 64'(bus.ack_out), 64'd1);
      chk("single busy@ack", 64'(bus.busy_out), 64'd1);
      chk("single id@ack", 64'(bus.id_out), 64'd0);
      chk("single eng_value", 64'(bus.eng_value_out), 64'd5);
      chk("single eng_exp", 64'(bus.eng_exponent_out), 64'd3);
      chk("single eng_mod", 64'(bus.eng_modulus_out), 64'd13);
      chk("single no early start", 64'(bus.eng_ready_out), 64'd0);
      bus.req_in = 2'b00;
      tick();
      chk("single start pulse", 64'(bus.eng_ready_out), 64'd1);
      chk("single ack is one cycle", 64'(bus.ack_out), 64'd0);
      tick();
      chk("single start ends", 64'(bus.eng_ready_out), 64'd0);
      lat = 3;
      while (bus.eng_valid_in !== 1'b1 && lat < 40) begin tick(); lat++; end
      chk("single done not at valid+1", 64'(bus.done_out), 64'd0);
      tick();
      lat++;
      chk("single done", 64'(bus.done_out), 64'd1);
      chk("single value", 64'(bus.value_out), 64'd8);
      chk("single id", 64'(bus.id_out), 64'd0);
      chk("single busy@done", 64'(bus.busy_out), 64'd1);
      chk("single end-to-end latency", 64'(lat), 64'(LAT + 4));
      chk("single one start pulse", 64'(ready_cnt - rc), 64'd1);
      tick();
      chk("single done is one cycle", 64'(bus.done_out), 64'd0);
      chk("single busy drops", 64'(bus.busy_out), 64'd0);
      tick();

      // simultaneous requests, pointer at 1
      bus.req_in = 2'b11;
`ifdef MODEXP_ARB_FIXED_PRIO_EN
      serve("ptr1 first", 0, 32'd8, 1'b0);
      serve("ptr1 second", 1, 32'd1, 1'b0);
`else
      serve("ptr1 first", 1, 32'd1, 1'b0);
      serve("ptr1 second", 0, 32'd8, 1'b0);
`endif
      repeat (2) tick();

      // request raised and dropped while busy is never served
      bus.req_in = 2'b10;
      tick();
      chk("drop slot1 ack", 64'(bus.ack_out), 64'd2);
      bus.req_in = 2'b01;
      repeat (2) tick();
      bus.req_in = 2'b00;
      t = 0;
      while (bus.done_out == '0 && t < 60) begin tick(); t++; end
      chk("drop slot1 done", 64'(bus.done_out), 64'd2);
      chk("drop slot1 value", 64'(bus.value_out), 64'd1);
      ac = ack_cnt;
      rc = ready_cnt;
      repeat (8) tick();
      chk("drop no ack", 64'(ack_cnt - ac), 64'd0);
      chk("drop no start", 64'(ready_cnt - rc), 64'd0);
      chk("drop idle", 64'(bus.busy_out), 64'd0);

      // spurious engine valid in IDLE
      dc = done_cnt;
      force_valid = 1'b1;
      tick();
      force_valid = 1'b0;
      repeat (4) tick();
      chk("spurious no done", 64'(done_cnt - dc), 64'd0);
      chk("spurious no busy", 64'(bus.busy_out), 64'd0);
      chk("spurious no start", 64'(ready_cnt - rc), 64'd0);

      // starvation: both held for six jobs
      bus.req_in = 2'b11;
      for (int j = 0; j < 6; j++) begin
`ifdef MODEXP_ARB_FIXED_PRIO_EN
         es = 0;
`else
         es = j % 2;
`endif
         serve($sformatf("starve job%0d", j), es, (es == 0) ? 32'd8 : 32'd1, 1'b1);
      end
      bus.req_in = 2'b00;
      repeat (3) tick();

      // operand stability: inputs change right after ack
      set_slot(0, 16'd5, 32'd3, 32'd13);
      bus.req_in = 2'b01;
      tick();
      chk("stab ack", 64'(bus.ack_out), 64'd1);
      set_slot(0, 16'd2, 32'd10, 32'd1000);
      bus.req_in = 2'b00;
      tick();
      chk("stab mid eng_value", 64'(bus.eng_value_out), 64'd5);
      chk("stab mid eng_exp", 64'(bus.eng_exponent_out), 64'd3);
      t = 0;
      while (bus.done_out == '0 && t < 60) begin tick(); t++; end
      chk("stab done", 64'(bus.done_out), 64'd1);
      chk("stab value", 64'(bus.value_out), 64'd8);
      chk("stab eng_mod@done", 64'(bus.eng_modulus_out), 64'd13);
      tick();
      chk("stab eng_exp after done", 64'(bus.eng_exponent_out), 64'd3);
      chk("stab eng_value after done", 64'(bus.eng_value_out), 64'd5);
      repeat (2) tick();

      // reset abort mid-WAIT
      bus.req_in = 2'b10;
      tick();
      chk("abort ack", 64'(bus.ack_out), 64'd2);
      bus.req_in = 2'b00;
      t = 0;
      while (bus.eng_ready_out !== 1'b1 && t < 20) begin tick(); t++; end
      tick();
      dc = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("abort busy", 64'(bus.busy_out), 64'd0);
      chk("abort value", 64'(bus.value_out), 64'd0);
      chk("abort id", 64'(bus.id_out), 64'd0);
      chk("abort eng_value", 64'(bus.eng_value_out), 64'd0);
      chk("abort eng_mod", 64'(bus.eng_modulus_out), 64'd0);
      chk("abort eng_rst", 64'(bus.eng_rst_out), 64'd1);
      chk("abort done", 64'(bus.done_out), 64'd0);
      tick();
      rst_n = 1'b1;
      repeat (8) tick();
      chk("abort no done pulse", 64'(done_cnt - dc), 64'd0);
      chk("abort idle", 64'(bus.busy_out), 64'd0);

      // new request after abort; slot 0 still holds (2,10,1000): 1024 mod 1000
      bus.req_in = 2'b01;
      serve("post-reset", 0, 32'd24, 1'b0);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
